// File: rtl/shift_arbiter_seq_pkg.sv
// Shared parameters for the shift arbiter: default widths, FSM state
// encodings and shift direction encodings.
package shift_arbiter_seq_pkg;

   localparam int DATA_BUS_WIDTH = 24;
   localparam int SHAMT_WIDTH    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_arbiter_seq_rr_arb.sv
// Two-way round-robin grant for shift_arbiter_seq. Purely combinational.
// On contention the requester that did not win last time gets the grant;
// a lone request always wins. No grant while disabled.
module shift_rr_arb (
   input  logic [1:0] valid,
   input  logic       lastGrant,
   input  logic       enable,
   output logic [1:0] grant
);

   // One-hot grant; bit 0 is requester 0.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11) begin
            grant = lastGrant ? 2'b01 : 2'b10;
         end else begin
            grant = valid;
         end
      end
   end

endmodule

// File: rtl/shift_arbiter_seq.sv
// Two-requester shift unit: round-robin accept, then a logical shift of the
// latched operand, result held until the consumer takes it.
// Build option SHIFT_FAST_EN: when defined, the whole shift is done with a
// barrel shifter in the accept cycle and the SHIFT state is never entered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; accept happens here only
// SHIFT | shifting the working register one bit per cycle
// DONE  | result presented, held until resultReady
module shift_arbiter_seq #(
   parameter int DATA_BUS_WIDTH = shift_arbiter_seq_pkg::DATA_BUS_WIDTH,
   parameter int SHAMT_WIDTH    = shift_arbiter_seq_pkg::SHAMT_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req0Valid,
   input  logic                      req1Valid,
   output logic                      req0Ready,
   output logic                      req1Ready,
   input  logic [DATA_BUS_WIDTH-1:0] req0Data,
   input  logic [DATA_BUS_WIDTH-1:0] req1Data,
   input  logic [SHAMT_WIDTH-1:0]    req0Amt,
   input  logic [SHAMT_WIDTH-1:0]    req1Amt,
   input  logic                      req0Dir,
   input  logic                      req1Dir,
   output logic                      resultValid,
   input  logic                      resultReady,
   output logic [DATA_BUS_WIDTH-1:0] resultData,
   output logic                      resultId,
   output logic                      busy
);

   import shift_arbiter_seq_pkg::*;

   stateT                     state;
   logic [DATA_BUS_WIDTH-1:0] work;
   logic [SHAMT_WIDTH-1:0]    cnt;
   logic                      dirReg;
   logic                      idReg;
   logic                      lastGrant;
   logic [1:0]                grant;
   logic                      arbEnable;

   logic                      selId;
   logic [DATA_BUS_WIDTH-1:0] selData;
   logic [SHAMT_WIDTH-1:0]    selAmt;
   logic                      selDir;

   // Ready is gated by reset so nothing looks accepted while reset is held.
   assign arbEnable = (state == IDLE) && !reset;

   shift_rr_arb uArb (
      .valid     ({req1Valid, req0Valid}),
      .lastGrant (lastGrant),
      .enable    (arbEnable),
      .grant     (grant)
   );

   assign req0Ready = grant[0];
   assign req1Ready = grant[1];

   // Operand of the winning requester.
   always_comb begin
      selId   = grant[1];
      selData = grant[1] ? req1Data : req0Data;
      selAmt  = grant[1] ? req1Amt  : req0Amt;
      selDir  = grant[1] ? req1Dir  : req0Dir;
   end

   assign busy        = (state != IDLE);
   assign resultValid = (state == DONE);
   assign resultData  = work;
   assign resultId    = idReg;

   // Control FSM with the working register and the down-counter.
   // The counter holds the shifts still to do; terminal count is 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         dirReg    <= DIR_LEFT;
         idReg     <= 1'b0;
         lastGrant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  idReg     <= selId;
                  lastGrant <= selId;
                  dirReg    <= selDir;
`ifdef SHIFT_FAST_EN
                  work  <= (selDir == DIR_RIGHT) ? (selData >> selAmt) : (selData << selAmt);
                  cnt   <= '0;
                  state <= DONE;
`else
                  work  <= selData;
                  cnt   <= selAmt;
                  state <= (selAmt == '0) ? DONE : SHIFT;
`endif
               end
            end
            SHIFT: begin
               work <= (dirReg == DIR_RIGHT) ? (work >> 1) : (work << 1);
               cnt  <= cnt - 1'b1;
               if (cnt == SHAMT_WIDTH'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (resultReady) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
